// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle control FSM sequencing fetch/decode/execute/memory/writeback
// with a memory-wait watchdog that halts the core on a hung bus.
module ctrl_unit #(
  parameter int TIMEOUT = 16,
  parameter int CW = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ack,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [3:0] alu_op,
  output logic       alu_en,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic flt, waiting, expire, is_alu, is_arith;
  assign waiting  = (cur == FETCH || cur == MEM) && !mem_ack;
  assign expire   = (TIMEOUT != 0) && waiting && cnt == CW'(TIMEOUT - 1);
  assign is_arith = opcode >= 4'd1 && opcode <= 4'd8;
  assign is_alu   = is_arith || opcode == 4'd11;
  assign state    = cur;
  assign fault    = flt;
  // Strobes are gated by rst_n so an asserted reset kills them without a clock edge.
  always_comb begin
    nxt      = cur;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    alu_op   = 4'd0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    halted   = 1'b0;
    if (rst_n) begin
      case (cur)
        FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ack;
          pc_inc  = mem_ack;
          nxt     = mem_ack ? DECODE : expire ? HALT : FETCH;
        end
        DECODE: nxt = EXEC;
        EXEC: begin
          alu_en  = is_alu;
          alu_op  = is_arith ? opcode : 4'd0;
          pc_load = opcode == 4'd12 || (opcode == 4'd13 && zero_flag);
          nxt     = is_alu ? WB : (opcode == 4'd9 || opcode == 4'd10) ? MEM : opcode == 4'd15 ? HALT : FETCH;
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = opcode == 4'd10;
          nxt      = mem_ack ? (opcode == 4'd9 ? WB : FETCH) : expire ? HALT : MEM;
        end
        WB: begin
          rf_we  = 1'b1;
          wb_sel = opcode == 4'd9;
          nxt    = FETCH;
        end
        HALT: begin
          halted = 1'b1;
          nxt    = HALT;
        end
        default: nxt = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= FETCH;
      cnt <= '0;
      flt <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= waiting ? cnt + 1'b1 : '0;
      flt <= flt | expire;
    end
  end
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: directed literal checks plus randomized run against a route-based
// instruction model compared on every negative clock edge.
module tb_ctrl_unit;
  localparam int T = 16;
  logic clk, rst_n, zero_flag, mem_ack;
  logic [3:0] opcode, alu_op;
  logic ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel, alu_en, rf_we, wb_sel, halted, fault;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0;
  int m_ph = 0, m_idx = 0, m_cnt = 0;
  logic m_flt = 1'b0;
  int stall = 0;

  ctrl_unit #(.TIMEOUT(T), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_op(alu_op), .alu_en(alu_en), .rf_we(rf_we), .wb_sel(wb_sel),
    .halted(halted), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_alu_op(logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd8) || op == 4'd11;
  endfunction

  // Instruction route: the sequence of phases an opcode walks through with zero-wait memory.
  function automatic int rlen(logic [3:0] op);
    if (is_alu_op(op)) return 4;
    if (op == 4'd9) return 5;
    if (op == 4'd10 || op == 4'd15) return 4;
    return 3;
  endfunction

  function automatic int phase_at(logic [3:0] op, int i);
    if (i < 3) return i;
    if (i == 4) return 4;
    if (op == 4'd15) return 5;
    if (op == 4'd9 || op == 4'd10) return 3;
    return 4;
  endfunction

  function automatic logic [17:0] expv(int ph, logic [3:0] op, logic z, logic a, logic f);
    logic [3:0] aop;
    aop = (ph == 2 && op >= 4'd1 && op <= 4'd8) ? op : 4'd0;
    return {ph == 0 && a, ph == 0 && a, ph == 2 && (op == 4'd12 || (op == 4'd13 && z)),
            ph == 0 || ph == 3, ph == 3 && op == 4'd10, ph == 3, aop,
            ph == 2 && is_alu_op(op), ph == 4, ph == 4 && op == 4'd9, ph == 5, f, 3'(ph)};
  endfunction

  always @(negedge clk) begin
    logic [17:0] e, g;
    logic w;
    g = {ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel, alu_op, alu_en, rf_we, wb_sel, halted, fault, state};
    e = rst_n ? expv(m_ph, opcode, zero_flag, mem_ack, m_flt) : 18'd0;
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, g, e);
    end
    if (!rst_n) begin
      m_ph = 0; m_idx = 0; m_cnt = 0; m_flt = 1'b0;
    end else begin
      w = (m_ph == 0 || m_ph == 3) && !mem_ack;
      if (m_ph == 5) m_cnt = 0;
      else if (w && m_cnt == T - 1) begin
        m_ph = 5; m_flt = 1'b1; m_cnt = 0;
      end else if (w) m_cnt++;
      else begin
        m_cnt = 0;
        m_idx = (m_idx + 1 == rlen(opcode)) ? 0 : m_idx + 1;
        m_ph = phase_at(opcode, m_idx);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'd1; zero_flag = 1'b0; mem_ack = 1'b1;
    #2;
    lit("rst_state", state, 0); lit("rst_mem_req", mem_req, 0); lit("rst_ir_load", ir_load, 0);
    nc(); rst_n = 1'b1; #1;
    lit("add_f_ir", ir_load, 1); lit("add_f_pc", pc_inc, 1); lit("add_f_st", state, 0);
    nc(); #1; lit("add_d_st", state, 1);
    nc(); #1; lit("add_e_st", state, 2); lit("add_e_en", alu_en, 1); lit("add_e_op", alu_op, 1);
    nc(); #1; lit("add_w_st", state, 4); lit("add_w_rf", rf_we, 1); lit("add_w_sel", wb_sel, 0);
    nc(); opcode = 4'd9; #1; lit("add_done", state, 0);
    nc(); #1;
    nc(); mem_ack = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      nc(); mem_ack = (i == 3); #1;
      lit("ld_st", state, 3); lit("ld_req", mem_req, 1); lit("ld_as", addr_sel, 1); lit("ld_we", mem_we, 0);
    end
    nc(); mem_ack = 1'b1; #1; lit("ld_wb", state, 4); lit("ld_wbsel", wb_sel, 1); lit("ld_rf", rf_we, 1);
    nc(); opcode = 4'd10; #1; lit("ld_done", state, 0);
    nc(); #1;
    nc(); #1;
    nc(); #1; lit("st_mem", state, 3); lit("st_we", mem_we, 1);
    nc(); opcode = 4'd13; zero_flag = 1'b1; #1; lit("st_nowb", state, 0);
    nc(); #1;
    nc(); #1; lit("jz1_st", state, 2); lit("jz1_pcl", pc_load, 1);
    nc(); zero_flag = 1'b0; #1; lit("jz1_done", state, 0);
    nc(); #1;
    nc(); #1; lit("jz0_st", state, 2); lit("jz0_pcl", pc_load, 0);
    nc(); opcode = 4'd15; #1; lit("jz0_done", state, 0);
    nc(); #1;
    nc(); #1;
    nc(); #1; lit("halt_st", state, 5); lit("halt_h", halted, 1);
    for (int i = 0; i < 20; i++) begin
      nc(); mem_ack = 1'($urandom_range(0, 1)); #1;
      lit("halt_req", mem_req, 0); lit("halt_hold", halted, 1);
    end
    rst_n = 1'b0; #1; lit("rst_halt", halted, 0); lit("rst_halt_st", state, 0);
    nc(); rst_n = 1'b1; mem_ack = 1'b0; opcode = 4'd0; #1; lit("to_c1", state, 0);
    for (int i = 2; i <= 16; i++) begin
      nc(); #1; lit("to_wait", state, 0); lit("to_nofault", fault, 0);
    end
    nc(); #1; lit("to_fault", fault, 1); lit("to_halted", halted, 1);
    rst_n = 1'b0;
    nc(); rst_n = 1'b1; #1; lit("to_clr", fault, 0);
    for (int i = 2; i <= 15; i++) begin
      nc(); #1;
    end
    nc(); mem_ack = 1'b1; #1; lit("ack16_st", state, 0); lit("ack16_ir", ir_load, 1);
    nc(); #1; lit("ack16_dec", state, 1); lit("ack16_nf", fault, 0);
    nc(); #1; lit("nop_exec", state, 2);
    nc(); opcode = 4'd10; #1; lit("st2_f", state, 0);
    nc(); #1;
    nc(); #1;
    nc(); mem_ack = 1'b0; #1; lit("st2_mem", state, 3); lit("st2_we", mem_we, 1);
    rst_n = 1'b0; #1; lit("arst_req", mem_req, 0); lit("arst_we", mem_we, 0);
    nc(); rst_n = 1'b1; #1;
    lit("post_req", mem_req, 1); lit("post_as", addr_sel, 0); lit("post_st", state, 0);
    repeat (3000) begin
      nc();
      if (!rst_n) rst_n = 1'b1;
      else if (m_ph == 5 && $urandom_range(0, 3) == 0) rst_n = 1'b0;
      if (m_ph == 0) opcode = 4'($urandom_range(0, 15));
      zero_flag = 1'($urandom_range(0, 1));
      if (stall > 0) begin
        mem_ack = 1'b0;
        stall--;
      end else begin
        mem_ack = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 60) == 0) stall = $urandom_range(12, 18);
      end
    end
    nc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
